// File: rtl/action_motor_drive.sv
// rtl/action_motor_drive.sv - action-code decoder, maneuver sequencer and dual H-bridge PWM driver
module action_motor_drive #(
  parameter int unsigned PWM_PERIOD  = 5000,
  parameter int unsigned DUTY_SLOW   = 2000,
  parameter int unsigned DUTY_NORM   = 3500,
  parameter int unsigned DUTY_FAST   = 5000,
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned DEAD_CYCLES = 100
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic [3:0] action,
  output logic       dir_l,
  output logic       dir_r,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic       busy,
  output logic [1:0] spd_level
);

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_REV, ST_SPIN} state_t;

  localparam logic [15:0] CNT_LAST  = 16'(PWM_PERIOD - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
  localparam logic [15:0] DEAD_LOAD = 16'(DEAD_CYCLES);

  state_t      state_q, state_d;
  logic [1:0]  spd_q, spd_d;
  logic [31:0] hold_q, hold_d;
  logic [3:0]  act_prev_q;
  logic        spin_right_q, spin_right_d;
  logic [15:0] pwm_cnt_q;
  logic [15:0] shadow_l_q, shadow_r_q;
  logic [15:0] dead_l_q, dead_r_q, dead_l_d, dead_r_d;
  logic        dir_l_q, dir_r_q, pwm_l_q, pwm_r_q;
  logic        req_dir_l, req_dir_r;
  logic [15:0] req_duty_l, req_duty_r;

  function automatic logic [15:0] duty_of(input logic [1:0] lvl);
    case (lvl)
      2'd0:    duty_of = 16'(DUTY_SLOW);
      2'd1:    duty_of = 16'(DUTY_NORM);
      default: duty_of = 16'(DUTY_FAST);
    endcase
  endfunction

  // Next state, speed level and the per-side direction/duty request
  always_comb begin
    state_d      = state_q;
    spd_d        = spd_q;
    hold_d       = hold_q;
    spin_right_d = spin_right_q;
    req_dir_l    = dir_l_q;
    req_dir_r    = dir_r_q;
    req_duty_l   = '0;
    req_duty_r   = '0;
    case (state_q)
      ST_REV: begin
        req_dir_l  = 1'b0;
        req_dir_r  = 1'b0;
        req_duty_l = duty_of(spd_q);
        req_duty_r = duty_of(spd_q);
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          state_d = ST_SPIN;
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      ST_SPIN: begin
        req_dir_l  = spin_right_q;
        req_dir_r  = !spin_right_q;
        req_duty_l = duty_of(spd_q);
        req_duty_r = duty_of(spd_q);
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
        case (action)
          4'h1, 4'h2, 4'h3: spd_d = action[1:0] - 2'd1;
          4'hB: if (action != act_prev_q && spd_q != 2'd2) spd_d = spd_q + 2'd1;
          4'hC: if (action != act_prev_q && spd_q != 2'd0) spd_d = spd_q - 2'd1;
          default: ;
        endcase
        case (action)
          4'h1, 4'h2, 4'h3, 4'hB, 4'hC: begin
            req_dir_l  = 1'b1;
            req_dir_r  = 1'b1;
            req_duty_l = duty_of(spd_d);
            req_duty_r = duty_of(spd_d);
          end
          4'h4, 4'h5: begin
            req_dir_l  = 1'b1;
            req_dir_r  = 1'b1;
            req_duty_l = action[0] ? duty_of(spd_q) : 16'(DUTY_SLOW);
            req_duty_r = action[0] ? 16'(DUTY_SLOW) : duty_of(spd_q);
          end
          4'h6, 4'h7: begin
            req_dir_l  = action[0];
            req_dir_r  = !action[0];
            req_duty_l = duty_of(spd_q);
            req_duty_r = duty_of(spd_q);
          end
          4'hA: begin
            req_dir_l  = 1'b0;
            req_dir_r  = 1'b0;
            req_duty_l = duty_of(spd_q);
            req_duty_r = duty_of(spd_q);
          end
          4'h8, 4'h9: begin
            spin_right_d = action[0];
            hold_d       = '0;
            state_d      = ST_REV;
          end
          default: state_d = ST_STOP;
        endcase
      end
    endcase
  end

  // Dead-time counters: reload on any reversal request, otherwise count down to zero
  always_comb begin
    dead_l_d = dead_l_q;
    dead_r_d = dead_r_q;
    if (req_dir_l != dir_l_q) dead_l_d = DEAD_LOAD;
    else if (dead_l_q != '0)  dead_l_d = dead_l_q - 16'd1;
    if (req_dir_r != dir_r_q) dead_r_d = DEAD_LOAD;
    else if (dead_r_q != '0)  dead_r_d = dead_r_q - 16'd1;
  end

  // Sequencer registers
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q      <= ST_STOP;
      spd_q        <= 2'd1;
      hold_q       <= '0;
      act_prev_q   <= '0;
      spin_right_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      spd_q        <= spd_d;
      hold_q       <= hold_d;
      act_prev_q   <= action;
      spin_right_q <= spin_right_d;
    end
  end

  // PWM counter, boundary-loaded shadows, directions and registered PWM outputs;
  // the pending dead count gates the compare so a reversal never emits a pulse
  always_ff @(posedge clk_in) begin
    if (rst) begin
      pwm_cnt_q  <= '0;
      shadow_l_q <= '0;
      shadow_r_q <= '0;
      dead_l_q   <= '0;
      dead_r_q   <= '0;
      dir_l_q    <= 1'b1;
      dir_r_q    <= 1'b1;
      pwm_l_q    <= 1'b0;
      pwm_r_q    <= 1'b0;
    end else begin
      pwm_cnt_q <= (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + 16'd1;
      if (pwm_cnt_q == CNT_LAST) begin
        shadow_l_q <= req_duty_l;
        shadow_r_q <= req_duty_r;
      end
      dead_l_q <= dead_l_d;
      dead_r_q <= dead_r_d;
      dir_l_q  <= req_dir_l;
      dir_r_q  <= req_dir_r;
      pwm_l_q  <= (pwm_cnt_q < shadow_l_q) && (dead_l_d == '0);
      pwm_r_q  <= (pwm_cnt_q < shadow_r_q) && (dead_r_d == '0);
    end
  end

  assign dir_l     = dir_l_q;
  assign dir_r     = dir_r_q;
  assign pwm_l     = pwm_l_q;
  assign pwm_r     = pwm_r_q;
  assign busy      = (state_q == ST_REV) || (state_q == ST_SPIN);
  assign spd_level = spd_q;

endmodule

// File: tb/tb_action_motor_drive.sv
// tb/tb_action_motor_drive.sv - self-checking bench for action_motor_drive
module tb_action_motor_drive;

  localparam int PERIOD = 10;
  localparam int HOLD   = 20;
  localparam int DEAD   = 2;

  logic       clk_in = 1'b0;
  logic       rst    = 1'b1;
  logic [3:0] action = 4'hF;
  logic       dir_l, dir_r, pwm_l, pwm_r, busy;
  logic [1:0] spd_level;

  int errors = 0;
  int checks = 0;

  action_motor_drive #(
    .PWM_PERIOD(PERIOD), .DUTY_SLOW(3), .DUTY_NORM(6), .DUTY_FAST(10),
    .HOLD_CYCLES(HOLD), .DEAD_CYCLES(DEAD)
  ) dut (
    .clk_in(clk_in), .rst(rst), .action(action),
    .dir_l(dir_l), .dir_r(dir_r), .pwm_l(pwm_l), .pwm_r(pwm_r),
    .busy(busy), .spd_level(spd_level)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: maneuver tracked as a countdown of remaining locked cycles
  int m_cnt, m_sh_l, m_sh_r, m_dead_l, m_dead_r, m_man, m_spd, m_prev;
  bit m_dir_l, m_dir_r, m_pwm_l, m_pwm_r, m_side_r;
  bit m_valid = 0;

  function automatic int lvl_of(input int s);
    return (s == 0) ? 3 : (s == 1) ? 6 : 10;
  endfunction

  always @(posedge clk_in) begin
    bit rl, rr;
    int dl, dr, nd_l, nd_r;
    if (rst) begin
      m_valid = 1; m_cnt = 0; m_sh_l = 0; m_sh_r = 0; m_dead_l = 0; m_dead_r = 0;
      m_man = 0; m_spd = 1; m_prev = 0; m_dir_l = 1; m_dir_r = 1;
      m_pwm_l = 0; m_pwm_r = 0; m_side_r = 0;
    end else begin
      rl = m_dir_l; rr = m_dir_r; dl = 0; dr = 0;
      if (m_man > 0) begin
        if (m_man > HOLD) begin rl = 0; rr = 0; end
        else begin rl = m_side_r; rr = !m_side_r; end
        dl = lvl_of(m_spd); dr = dl;
        m_man--;
      end else begin
        case (int'(action))
          1, 2, 3: begin m_spd = int'(action) - 1; rl = 1; rr = 1; dl = lvl_of(m_spd); dr = dl; end
          4: begin rl = 1; rr = 1; dl = 3; dr = lvl_of(m_spd); end
          5: begin rl = 1; rr = 1; dl = lvl_of(m_spd); dr = 3; end
          6: begin rl = 0; rr = 1; dl = lvl_of(m_spd); dr = dl; end
          7: begin rl = 1; rr = 0; dl = lvl_of(m_spd); dr = dl; end
          10: begin rl = 0; rr = 0; dl = lvl_of(m_spd); dr = dl; end
          11, 12: begin
            if (int'(action) != m_prev) begin
              if (action == 4'hB && m_spd < 2) m_spd++;
              if (action == 4'hC && m_spd > 0) m_spd--;
            end
            rl = 1; rr = 1; dl = lvl_of(m_spd); dr = dl;
          end
          8, 9: begin m_man = 2 * HOLD; m_side_r = (action == 4'h9); end
          default: ;
        endcase
      end
      m_prev = int'(action);
      nd_l = (rl != m_dir_l) ? DEAD : (m_dead_l > 0 ? m_dead_l - 1 : 0);
      nd_r = (rr != m_dir_r) ? DEAD : (m_dead_r > 0 ? m_dead_r - 1 : 0);
      m_pwm_l = (m_cnt < m_sh_l) && (nd_l == 0);
      m_pwm_r = (m_cnt < m_sh_r) && (nd_r == 0);
      if (m_cnt == PERIOD - 1) begin m_sh_l = dl; m_sh_r = dr; end
      m_cnt = (m_cnt + 1) % PERIOD;
      m_dir_l = rl; m_dir_r = rr; m_dead_l = nd_l; m_dead_r = nd_r;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk_in) begin
    if (m_valid) begin
      chk("model dir_l", dir_l, m_dir_l);
      chk("model dir_r", dir_r, m_dir_r);
      chk("model pwm_l", pwm_l, m_pwm_l);
      chk("model pwm_r", pwm_r, m_pwm_r);
      chk("model busy", busy, (m_man > 0));
      chk("model spd_level", spd_level, m_spd);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic count_pwm(input int n, output int cl, output int cr);
    cl = 0; cr = 0;
    repeat (n) begin
      @(negedge clk_in);
      cl += int'(pwm_l);
      cr += int'(pwm_r);
    end
  endtask

  initial begin
    int cl, cr, nb, nl, nr;
    rst = 1'b1; action = 4'hF;
    step(3);
    rst = 1'b0;

    // Idle after reset with action F
    count_pwm(30, cl, cr);
    chk("idle pwm_l highs", cl, 0);
    chk("idle pwm_r highs", cr, 0);
    chk("idle spd_level", spd_level, 1);
    chk("idle dir_l", dir_l, 1);
    chk("idle dir_r", dir_r, 1);
    chk("idle busy", busy, 0);

    // Fast = 100 % duty, then slow = 3 of 10
    action = 4'h3; step(25);
    chk("fast spd_level", spd_level, 2);
    count_pwm(PERIOD, cl, cr);
    chk("fast pwm_l highs", cl, 10);
    chk("fast pwm_r highs", cr, 10);
    action = 4'h1; step(25);
    chk("slow spd_level", spd_level, 0);
    count_pwm(PERIOD, cl, cr);
    chk("slow pwm_l highs", cl, 3);
    chk("slow pwm_r highs", cr, 3);

    // Normal forward, then quick left with dead time on the left side
    action = 4'h2; step(25);
    count_pwm(PERIOD, cl, cr);
    chk("norm pwm_l highs", cl, 6);
    action = 4'h6; step(1);
    chk("qleft dir_l after 1", dir_l, 0);
    chk("qleft dir_r", dir_r, 1);
    chk("qleft dead pwm_l 1", pwm_l, 0);
    step(1);
    chk("qleft dead pwm_l 2", pwm_l, 0);
    step(20);
    count_pwm(PERIOD, cl, cr);
    chk("qleft pwm_l highs", cl, 6);
    chk("qleft pwm_r highs", cr, 6);

    // Left maneuver: held 8 for 5 cycles then 2
    action = 4'h2; step(25);
    action = 4'h8;
    nb = 0; nl = 0; nr = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      if (i == 0) chk("man busy rise", busy, 1);
      nb += int'(busy);
      nl += int'(!dir_l);
      nr += int'(!dir_r);
      if (i == 4) action = 4'h2;
    end
    chk("man busy cycles", nb, 40);
    chk("man dir_l reverse cycles", nl, 40);
    chk("man dir_r reverse cycles", nr, 20);
    count_pwm(PERIOD, cl, cr);
    chk("after man pwm_l highs", cl, 6);
    chk("after man pwm_r highs", cr, 6);

    // Speed stepping with edge detect and saturation
    action = 4'hB; step(100);
    chk("B held spd", spd_level, 2);
    action = 4'hF; step(1);
    action = 4'hB; step(5);
    chk("B saturate spd", spd_level, 2);
    action = 4'hC; step(5);
    chk("C once spd", spd_level, 1);
    action = 4'h2; step(5);
    chk("action 2 spd", spd_level, 1);
    action = 4'hC; step(5);
    chk("C to slow spd", spd_level, 0);

    // Reset during SPIN aborts the maneuver
    action = 4'h9; step(30);
    chk("spin busy", busy, 1);
    chk("spin dir_r", dir_r, 0);
    rst = 1'b1; action = 4'hF; step(1);
    chk("rst busy", busy, 0);
    chk("rst pwm_l", pwm_l, 0);
    chk("rst pwm_r", pwm_r, 0);
    chk("rst dir_r", dir_r, 1);
    rst = 1'b0;
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_in);
      nb += int'(busy);
    end
    chk("no resume busy", nb, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
